step_ctrl: RTL

Clock-enable generator for the single-cycle and pipelined MIPS cores. Consumes the free-running `clkdiv` bus and the `clk100mhz` clock from the clock-divider stage, debounces the board step button, and emits a one-cycle `cpu_en` strobe to gate the core:
- step mode: one strobe per press;
- run mode: periodic strobes at a switch-selected rate.

Also counts issued strobes for the display logic.

---
 rtl/step_ctrl_pkg.sv | 17 +
 rtl/btn_debounce.sv | 51 +++++
 rtl/step_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/step_ctrl_pkg.sv
// Shared types and constants for the step_ctrl clock-enable generator.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_HELD = 2'd2,
    S_RUN  = 2'd3
  } state_e;

  localparam logic [1:0] SPEED_FULL = 2'd3;

  // Autorepeat timing, in debounce ticks of continuous hold.
  localparam int unsigned AR_DELAY_TICKS  = 64;
  localparam int unsigned AR_PERIOD_TICKS = 8;

endpackage

// File: rtl/btn_debounce.sv
// Step-button debouncer: 2-FF synchroniser plus tick-sampled consecutive-disagreement counter.
module btn_debounce #(
  parameter int unsigned DEB_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic level
);

  localparam logic [3:0] CNT_TERM = 4'(DEB_SAMPLES);

  logic       din_s1_q, din_s2_q;
  logic [3:0] cnt_q, cnt_d;
  logic       level_q, level_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (tick) begin
      if (din_s2_q != level_q) begin
        if (cnt_q + 4'd1 == CNT_TERM) begin
          level_d = ~level_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_s1_q <= 1'b0;
      din_s2_q <= 1'b0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
    end else begin
      din_s1_q <= din;
      din_s2_q <= din_s1_q;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: one-cycle cpu_en strobes for single-step or free-run of the MIPS cores.
// Optional held-button autorepeat is built when STEP_CTRL_AUTOREPEAT_EN is defined.
//
// state  | meaning
// S_IDLE | step mode, waiting for a debounced press
// S_FIRE | issue the single step strobe
// S_HELD | button still down after a strobe, waiting for release
// S_RUN  | periodic strobes at the sw_speed rate
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int unsigned TICK_BIT    = 17,
  parameter int unsigned DEB_SAMPLES = 4,
  parameter int unsigned RUN_BIT     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clkdiv,
  input  logic        btn_step,
  input  logic        sw_run,
  input  logic [1:0]  sw_speed,
  output logic        cpu_en,
  output logic        btn_level,
  output logic [15:0] step_cnt
);

  logic [2:0]  tick_sync_q;
  logic [2:0]  rbit_sync_q;
  logic        run_s1_q, run_s2_q;
  logic [1:0]  spd_s1_q, spd_s2_q;
  logic        run_edge_q;
  logic        lvl_prev_q;
  state_e      state_q, state_d;
  logic        cpu_en_q, cpu_en_d;
  logic [15:0] step_cnt_q;
  logic        tick;
  logic        level;
  logic        run_bit_raw;
  logic        rep_fire;
  logic        unused_clkdiv;

  // Only a few divider bits are consumed; fold the rest away.
  assign unused_clkdiv = ^clkdiv;

  always_comb begin
    case (spd_s2_q)
      2'd0:    run_bit_raw = clkdiv[RUN_BIT];
      2'd1:    run_bit_raw = clkdiv[RUN_BIT+1];
      default: run_bit_raw = clkdiv[RUN_BIT+2];
    endcase
  end

  assign tick = tick_sync_q[1] & ~tick_sync_q[2];

  btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .din   (btn_step),
    .level (level)
  );

`ifdef STEP_CTRL_AUTOREPEAT_EN
  logic [6:0] hold_cnt_q, hold_cnt_d;

  // Hold counter only runs while parked in S_HELD, so any exit re-arms the delay.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    rep_fire   = 1'b0;
    if (state_q != S_HELD) begin
      hold_cnt_d = '0;
    end else if (tick) begin
      if (hold_cnt_q == 7'(AR_DELAY_TICKS + AR_PERIOD_TICKS - 1)) begin
        rep_fire   = level;
        hold_cnt_d = 7'(AR_DELAY_TICKS);
      end else begin
        hold_cnt_d = hold_cnt_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_cnt_q <= '0;
    else     hold_cnt_q <= hold_cnt_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cpu_en_d = rep_fire;
    unique case (state_q)
      S_IDLE: begin
        if (run_s2_q)                 state_d = S_RUN;
        else if (level && !lvl_prev_q) state_d = S_FIRE;
      end
      S_FIRE: begin
        cpu_en_d = 1'b1;
        state_d  = S_HELD;
      end
      S_HELD: begin
        if (run_s2_q)    state_d = S_RUN;
        else if (!level) state_d = S_IDLE;
      end
      S_RUN: begin
        cpu_en_d = (spd_s2_q == SPEED_FULL) || run_edge_q;
        if (!run_s2_q) state_d = level ? S_HELD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_sync_q <= '0;
      rbit_sync_q <= '0;
      run_s1_q    <= 1'b0;
      run_s2_q    <= 1'b0;
      spd_s1_q    <= '0;
      spd_s2_q    <= '0;
      run_edge_q  <= 1'b0;
      lvl_prev_q  <= 1'b0;
      state_q     <= S_IDLE;
      cpu_en_q    <= 1'b0;
      step_cnt_q  <= '0;
    end else begin
      tick_sync_q <= {tick_sync_q[1:0], clkdiv[TICK_BIT]};
      rbit_sync_q <= {rbit_sync_q[1:0], run_bit_raw};
      run_s1_q    <= sw_run;
      run_s2_q    <= run_s1_q;
      spd_s1_q    <= sw_speed;
      spd_s2_q    <= spd_s1_q;
      run_edge_q  <= rbit_sync_q[1] & ~rbit_sync_q[2];
      lvl_prev_q  <= level;
      state_q     <= state_d;
      cpu_en_q    <= cpu_en_d;
      step_cnt_q  <= step_cnt_q + {15'd0, cpu_en_q};
    end
  end

  assign cpu_en    = cpu_en_q;
  assign btn_level = level;
  assign step_cnt  = step_cnt_q;

endmodule
